// File: rtl/rcn_pkg.sv
// Shared rcn bus field widths and the buffered request-entry layout.
package rcn_pkg;

   localparam int RCN_SEQ_W  = 2;
   localparam int RCN_MASK_W = 4;
   localparam int RCN_ADDR_W = 22;
   localparam int RCN_DATA_W = 32;
   localparam int RCN_TAGS   = 2 ** RCN_SEQ_W;

   // One FIFO entry: wr, mask, addr, wdata (59 bits, wr in the MSB).
   localparam int RCN_REQ_W  = 1 + RCN_MASK_W + RCN_ADDR_W + RCN_DATA_W;

   typedef struct packed {
      logic                  wr;
      logic [RCN_MASK_W-1:0] mask;
      logic [RCN_ADDR_W-1:0] addr;
      logic [RCN_DATA_W-1:0] wdata;
   } rcn_req_t;

endpackage

// File: rtl/rcn_fifo.sv
// Generic synchronous FIFO, 2**DEPTH_LOG2 entries, head visible without a read strobe.
// Push is ignored while full and pop while empty.
module rcn_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  do_push, do_pop;

   assign full  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = do_push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
         2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/rcn_master_buf.sv
// Request queue and 2-bit seq tag manager in front of the rcn bus master.
// Optional RCN_MASTER_BUF_STATS_EN adds saturating read/write/stall counters.
module rcn_master_buf
   import rcn_pkg::*;
#(
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wr,
   input  logic [RCN_MASK_W-1:0] req_mask,
   input  logic [RCN_ADDR_W-1:0] req_addr,
   input  logic [RCN_DATA_W-1:0] req_wdata,
   output logic                  m_cs,
   output logic [RCN_SEQ_W-1:0]  m_seq,
   output logic                  m_wr,
   output logic [RCN_MASK_W-1:0] m_mask,
   output logic [RCN_ADDR_W-1:0] m_addr,
   output logic [RCN_DATA_W-1:0] m_wdata,
   input  logic                  m_busy,
   input  logic                  m_rdone,
   input  logic                  m_wdone,
   input  logic [RCN_SEQ_W-1:0]  m_rsp_seq,
   input  logic [RCN_MASK_W-1:0] m_rsp_mask,
   input  logic [RCN_ADDR_W-1:0] m_rsp_addr,
   input  logic [RCN_DATA_W-1:0] m_rsp_data,
   output logic                  rsp_valid,
   output logic                  rsp_wr,
   output logic [RCN_SEQ_W-1:0]  rsp_seq,
   output logic [RCN_MASK_W-1:0] rsp_mask,
   output logic [RCN_ADDR_W-1:0] rsp_addr,
   output logic [RCN_DATA_W-1:0] rsp_data,
   output logic                  seq_err,
   output logic                  idle
`ifdef RCN_MASTER_BUF_STATS_EN
   ,
   output logic [15:0]           stat_rd,
   output logic [15:0]           stat_wr,
   output logic [15:0]           stat_stall
`endif
);

   logic [RCN_REQ_W-1:0] fifo_rdata;
   logic                 fifo_full, fifo_empty;
   logic [DEPTH_LOG2:0]  fifo_count;
   rcn_req_t             head;
   logic                 cs, issue, rsp_any;
   logic [RCN_TAGS-1:0]  tag_set, tag_clr;

   logic [RCN_TAGS-1:0]   inflight_q, inflight_d;
   logic [RCN_SEQ_W-1:0]  next_seq_q, next_seq_d;
   logic                  seq_err_q, seq_err_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_wr_q, rsp_wr_d;
   logic [RCN_SEQ_W-1:0]  rsp_seq_q, rsp_seq_d;
   logic [RCN_MASK_W-1:0] rsp_mask_q, rsp_mask_d;
   logic [RCN_ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
   logic [RCN_DATA_W-1:0] rsp_data_q, rsp_data_d;

   rcn_fifo #(
      .WIDTH      (RCN_REQ_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (req_valid),
      .pop   (issue),
      .wdata ({req_wr, req_mask, req_addr, req_wdata}),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // cs looks only at registered state so m_busy may safely depend on m_cs.
   assign cs      = !fifo_empty && !inflight_q[next_seq_q];
   assign issue   = cs && !m_busy;
   assign rsp_any = m_rdone || m_wdone;

   always_comb begin
      head = fifo_empty ? '0 : rcn_req_t'(fifo_rdata);
   end

   // Set and clear never hit the same tag: set needs it free, clear needs it busy.
   genvar gi;
   generate
      for (gi = 0; gi < RCN_TAGS; gi++) begin : g_tag
         assign tag_set[gi] = issue && (next_seq_q == RCN_SEQ_W'(gi));
         assign tag_clr[gi] = rsp_any && (m_rsp_seq == RCN_SEQ_W'(gi)) && inflight_q[gi];
      end
   endgenerate

   always_comb begin
      inflight_d  = (inflight_q | tag_set) & ~tag_clr;
      next_seq_d  = issue ? next_seq_q + RCN_SEQ_W'(1) : next_seq_q;
      seq_err_d   = seq_err_q || (rsp_any && !inflight_q[m_rsp_seq]);
      rsp_valid_d = rsp_any;
      rsp_wr_d    = rsp_wr_q;
      rsp_seq_d   = rsp_seq_q;
      rsp_mask_d  = rsp_mask_q;
      rsp_addr_d  = rsp_addr_q;
      rsp_data_d  = rsp_data_q;
      if (rsp_any) begin
         rsp_wr_d   = m_wdone;
         rsp_seq_d  = m_rsp_seq;
         rsp_mask_d = m_rsp_mask;
         rsp_addr_d = m_rsp_addr;
         rsp_data_d = m_rsp_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q  <= '0;
         next_seq_q  <= '0;
         seq_err_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_wr_q    <= 1'b0;
         rsp_seq_q   <= '0;
         rsp_mask_q  <= '0;
         rsp_addr_q  <= '0;
         rsp_data_q  <= '0;
      end else begin
         inflight_q  <= inflight_d;
         next_seq_q  <= next_seq_d;
         seq_err_q   <= seq_err_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_wr_q    <= rsp_wr_d;
         rsp_seq_q   <= rsp_seq_d;
         rsp_mask_q  <= rsp_mask_d;
         rsp_addr_q  <= rsp_addr_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign req_ready = !fifo_full;
   assign m_cs      = cs;
   assign m_seq     = next_seq_q;
   assign m_wr      = head.wr;
   assign m_mask    = head.mask;
   assign m_addr    = head.addr;
   assign m_wdata   = head.wdata;
   assign rsp_valid = rsp_valid_q;
   assign rsp_wr    = rsp_wr_q;
   assign rsp_seq   = rsp_seq_q;
   assign rsp_mask  = rsp_mask_q;
   assign rsp_addr  = rsp_addr_q;
   assign rsp_data  = rsp_data_q;
   assign seq_err   = seq_err_q;
   assign idle      = (fifo_count == '0) && (inflight_q == '0);

`ifdef RCN_MASTER_BUF_STATS_EN
   logic [15:0] stat_rd_q, stat_rd_d;
   logic [15:0] stat_wr_q, stat_wr_d;
   logic [15:0] stat_stall_q, stat_stall_d;

   always_comb begin
      stat_rd_d    = stat_rd_q;
      stat_wr_d    = stat_wr_q;
      stat_stall_d = stat_stall_q;
      if (issue && !head.wr && stat_rd_q != 16'hFFFF) begin
         stat_rd_d = stat_rd_q + 16'd1;
      end
      if (issue && head.wr && stat_wr_q != 16'hFFFF) begin
         stat_wr_d = stat_wr_q + 16'd1;
      end
      if (cs && m_busy && stat_stall_q != 16'hFFFF) begin
         stat_stall_d = stat_stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_rd_q    <= '0;
         stat_wr_q    <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_rd_q    <= stat_rd_d;
         stat_wr_q    <= stat_wr_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_rd    = stat_rd_q;
   assign stat_wr    = stat_wr_q;
   assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_rcn_master_buf.sv
// Directed bench for rcn_master_buf with issue and response scoreboards.
// Counter checks are compiled in only when RCN_MASTER_BUF_STATS_EN is defined.
module tb_rcn_master_buf;
   import rcn_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wr;
   logic [3:0]  req_mask;
   logic [21:0] req_addr;
   logic [31:0] req_wdata;
   logic        m_cs, m_wr;
   logic [1:0]  m_seq;
   logic [3:0]  m_mask;
   logic [21:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_busy, m_rdone, m_wdone;
   logic [1:0]  m_rsp_seq;
   logic [3:0]  m_rsp_mask;
   logic [21:0] m_rsp_addr;
   logic [31:0] m_rsp_data;
   logic        rsp_valid, rsp_wr;
   logic [1:0]  rsp_seq;
   logic [3:0]  rsp_mask;
   logic [21:0] rsp_addr;
   logic [31:0] rsp_data;
   logic        seq_err, idle;
`ifdef RCN_MASTER_BUF_STATS_EN
   logic [15:0] stat_rd, stat_wr, stat_stall;
`endif

   always #5 clk = ~clk;

   rcn_master_buf #(.DEPTH_LOG2(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wr     (req_wr),
      .req_mask   (req_mask),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .m_cs       (m_cs),
      .m_seq      (m_seq),
      .m_wr       (m_wr),
      .m_mask     (m_mask),
      .m_addr     (m_addr),
      .m_wdata    (m_wdata),
      .m_busy     (m_busy),
      .m_rdone    (m_rdone),
      .m_wdone    (m_wdone),
      .m_rsp_seq  (m_rsp_seq),
      .m_rsp_mask (m_rsp_mask),
      .m_rsp_addr (m_rsp_addr),
      .m_rsp_data (m_rsp_data),
      .rsp_valid  (rsp_valid),
      .rsp_wr     (rsp_wr),
      .rsp_seq    (rsp_seq),
      .rsp_mask   (rsp_mask),
      .rsp_addr   (rsp_addr),
      .rsp_data   (rsp_data),
      .seq_err    (seq_err),
      .idle       (idle)
`ifdef RCN_MASTER_BUF_STATS_EN
      ,
      .stat_rd    (stat_rd),
      .stat_wr    (stat_wr),
      .stat_stall (stat_stall)
`endif
   );

   typedef struct packed {
      logic [1:0]  seq;
      logic        wr;
      logic [3:0]  mask;
      logic [21:0] addr;
      logic [31:0] data;
   } xact_t;

   xact_t issue_q[$];
   xact_t rsp_q[$];
   int    vec      = 0;
   int    miss     = 0;
   int    push_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec++;
      assert (got === exp) else begin
         miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at the falling edge: decides what the coming rising edge transfers.
   task automatic monitor();
      xact_t e;
      if (m_cs && !m_busy) begin
         if (issue_q.size() == 0) begin
            chk("spurious_issue_pending", 64'(issue_q.size()), 64'd1);
         end else begin
            e = issue_q.pop_front();
            $display("issue seq=%0d wr=%0d mask=%h addr=%h data=%h", m_seq, m_wr, m_mask, m_addr, m_wdata);
            chk("issue", 64'({m_seq, m_wr, m_mask, m_addr, m_wdata}), 64'(e));
         end
      end
      if (rsp_valid) begin
         if (rsp_q.size() == 0) begin
            chk("spurious_rsp_pending", 64'(rsp_q.size()), 64'd1);
         end else begin
            e = rsp_q.pop_front();
            $display("rsp   seq=%0d wr=%0d mask=%h addr=%h data=%h", rsp_seq, rsp_wr, rsp_mask, rsp_addr, rsp_data);
            chk("rsp", 64'({rsp_seq, rsp_wr, rsp_mask, rsp_addr, rsp_data}), 64'(e));
         end
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      issue_q.delete();
      rsp_q.delete();
      push_cnt = 0;
   endtask

   task automatic push(input logic wr, input logic [3:0] mask, input logic [21:0] addr, input logic [31:0] data);
      xact_t e;
      chk("req_ready_at_push", 64'(req_ready), 64'd1);
      e.seq  = 2'(push_cnt);
      e.wr   = wr;
      e.mask = mask;
      e.addr = addr;
      e.data = data;
      issue_q.push_back(e);
      push_cnt++;
      req_valid = 1'b1;
      req_wr    = wr;
      req_mask  = mask;
      req_addr  = addr;
      req_wdata = data;
      cyc();
      req_valid = 1'b0;
   endtask

   task automatic respond(input logic wr, input logic [1:0] seq, input logic [3:0] mask, input logic [21:0] addr, input logic [31:0] data);
      xact_t e;
      e.seq  = seq;
      e.wr   = wr;
      e.mask = mask;
      e.addr = addr;
      e.data = data;
      rsp_q.push_back(e);
      m_wdone    = wr;
      m_rdone    = !wr;
      m_rsp_seq  = seq;
      m_rsp_mask = mask;
      m_rsp_addr = addr;
      m_rsp_data = data;
      cyc();
      m_wdone = 1'b0;
      m_rdone = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1;
      req_valid = 1'b0; req_wr = 1'b0; req_mask = '0; req_addr = '0; req_wdata = '0;
      m_busy = 1'b0; m_rdone = 1'b0; m_wdone = 1'b0;
      m_rsp_seq = '0; m_rsp_mask = '0; m_rsp_addr = '0; m_rsp_data = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      chk("reset_ready", 64'(req_ready), 64'd1);
      chk("reset_idle", 64'(idle), 64'd1);
      chk("reset_m_bus", 64'({m_cs, m_seq, m_wr, m_mask, m_addr, m_wdata}), 64'd0);
      chk("reset_rsp", 64'({rsp_valid, rsp_wr, rsp_seq, rsp_mask, rsp_addr, rsp_data}), 64'd0);
      chk("reset_seq_err", 64'(seq_err), 64'd0);

      // Single read
      push(1'b0, 4'hF, 22'h000104, 32'h0);
      chk("single_cs", 64'(m_cs), 64'd1);
      chk("single_seq", 64'(m_seq), 64'd0);
      chk("single_not_idle", 64'(idle), 64'd0);
      cyc();
      respond(1'b0, 2'd0, 4'hF, 22'h000104, 32'hDEADBEEF);
      cyc();
      chk("single_rsp_pulse", 64'(rsp_valid), 64'd0);
      chk("single_idle", 64'(idle), 64'd1);

      // Busy hold
      m_busy = 1'b1;
      push(1'b1, 4'h5, 22'h2AAAAA, 32'h12345678);
      for (int i = 0; i < 5; i++) begin
         chk("hold_fields", 64'({m_cs, m_seq, m_wr, m_mask, m_addr, m_wdata}),
             64'({1'b1, 2'd1, 1'b1, 4'h5, 22'h2AAAAA, 32'h12345678}));
         cyc();
      end
      m_busy = 1'b0;
      chk("hold_cs_at_release", 64'(m_cs), 64'd1);
      cyc();
      chk("hold_popped", 64'(m_cs), 64'd0);
`ifdef RCN_MASTER_BUF_STATS_EN
      chk("stat_stall", 64'(stat_stall), 64'd5);
      chk("stat_rd", 64'(stat_rd), 64'd1);
      chk("stat_wr", 64'(stat_wr), 64'd1);
`endif
      respond(1'b1, 2'd1, 4'h5, 22'h2AAAAA, 32'hCAFEF00D);
      cyc();
      chk("hold_idle", 64'(idle), 64'd1);

      // Tag exhaustion
      reset_dut();
      for (int i = 0; i < 5; i++) begin
         push(1'b0, 4'hF, 22'(256 + i * 4), 32'(i));
      end
      cyc();
      cyc();
      chk("exhaust_cs_low", 64'(m_cs), 64'd0);
      chk("exhaust_pending", 64'(issue_q.size()), 64'd1);
      chk("exhaust_not_idle", 64'(idle), 64'd0);
      respond(1'b0, 2'd0, 4'hF, 22'h000100, 32'hA0A0A0A0);
      chk("exhaust_cs_freed", 64'(m_cs), 64'd1);
      chk("exhaust_reuse_seq", 64'(m_seq), 64'd0);
      cyc();
      respond(1'b0, 2'd1, 4'hF, 22'h000104, 32'hA1A1A1A1);
      respond(1'b0, 2'd2, 4'hF, 22'h000108, 32'hA2A2A2A2);
      respond(1'b0, 2'd3, 4'hF, 22'h00010C, 32'hA3A3A3A3);
      respond(1'b0, 2'd0, 4'hF, 22'h000110, 32'hA4A4A4A4);
      cyc();
      chk("exhaust_idle", 64'(idle), 64'd1);

      // FIFO full
      m_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push(1'b1, 4'(i + 1), 22'(22'h200 + i * 4), 32'(32'hF000 + i));
      end
      chk("full_ready_low", 64'(req_ready), 64'd0);
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 22'h3FFFF0; req_wdata = 32'hBAD0BAD0;
      cyc();
      req_valid = 1'b0;
      chk("full_still_low", 64'(req_ready), 64'd0);
      m_busy = 1'b0;
      chk("full_pop_cycle_ready", 64'(req_ready), 64'd0);
      cyc();
      chk("full_ready_after_pop", 64'(req_ready), 64'd1);
      n = 0;
      while (issue_q.size() != 0 && n < 20) begin
         cyc();
         n++;
      end
      chk("full_drain", 64'(issue_q.size()), 64'd0);
      cyc();
      chk("full_no_extra", 64'(m_cs), 64'd0);
      respond(1'b1, 2'd1, 4'h1, 22'h000200, 32'h1);
      respond(1'b1, 2'd2, 4'h2, 22'h000204, 32'h2);
      respond(1'b1, 2'd3, 4'h3, 22'h000208, 32'h3);
      respond(1'b1, 2'd0, 4'h4, 22'h00020C, 32'h4);
      cyc();
      chk("full_idle", 64'(idle), 64'd1);

      // Unknown tag
      respond(1'b1, 2'd2, 4'h3, 22'h3FFFFF, 32'h55AA55AA);
      cyc();
      chk("unknown_seq_err", 64'(seq_err), 64'd1);
      chk("unknown_still_idle", 64'(idle), 64'd1);
      repeat (3) cyc();
      chk("unknown_sticky", 64'(seq_err), 64'd1);

      // Reset mid-flight
      reset_dut();
      chk("rst_clears_seq_err", 64'(seq_err), 64'd0);
      push(1'b0, 4'hF, 22'h000040, 32'h0);
      push(1'b0, 4'hF, 22'h000044, 32'h0);
      cyc();
      chk("midflight_not_idle", 64'(idle), 64'd0);
      reset_dut();
      chk("midflight_idle", 64'(idle), 64'd1);
      chk("midflight_m_bus", 64'({m_cs, m_seq, m_wr, m_mask, m_addr, m_wdata}), 64'd0);
      chk("midflight_ready", 64'(req_ready), 64'd1);
      chk("midflight_rsp", 64'(rsp_valid), 64'd0);
      respond(1'b0, 2'd1, 4'hF, 22'h000044, 32'h11111111);
      cyc();
      chk("stale_seq_err", 64'(seq_err), 64'd1);
      push(1'b0, 4'hC, 22'h000080, 32'h0);
      chk("post_rst_seq", 64'(m_seq), 64'd0);
      cyc();
      respond(1'b0, 2'd0, 4'hC, 22'h000080, 32'h22222222);
      cyc();
      chk("final_idle", 64'(idle), 64'd1);
      chk("final_queues_empty", 64'(issue_q.size() + rsp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
